// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, 2-flop synchronised input.
// Ports: clk_i, rst_n (sync, active low), uart_rx_i (serial in),
//   rx_data_o (last good byte), rx_valid_o (1-cycle strobe),
//   frame_err_o (1-cycle, stop bit low), rx_busy_o (state != IDLE).
module uart_rx #(
    parameter int CLK_DIV  = 434,
    parameter int HALF_DIV = CLK_DIV / 2
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output logic       rx_busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [12:0] FULL_LD = 13'(CLK_DIV - 1);
    localparam logic [12:0] HALF_LD = 13'(HALF_DIV - 1);

    state_t      state, state_n;
    logic [12:0] cnt, cnt_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  data_n;
    logic        valid_n, ferr_n;
    logic        s1, s2, s2_d;
    logic        tick;

    assign tick      = (cnt == 13'd0);
    assign rx_busy_o = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 13'd0;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            s1          <= 1'b1;
            s2          <= 1'b1;
            s2_d        <= 1'b1;
            rx_data_o   <= 8'h00;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_n;
            shift       <= shift_n;
            s1          <= uart_rx_i;
            s2          <= s1;
            s2_d        <= s2;
            rx_data_o   <= data_n;
            rx_valid_o  <= valid_n;
            frame_err_o <= ferr_n;
        end
    end

    // Counter only decrements while non-zero; a state that
    // consumes a tick either reloads it or leaves it at 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = rx_data_o;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (s2_d && !s2) begin
                    state_n = S_START;
                    cnt_n   = HALF_LD;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_n = cnt - 13'd1;
                end else if (s2) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DATA;
                    cnt_n   = FULL_LD;
                    bit_n   = 3'd0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_n = cnt - 13'd1;
                end else begin
                    shift_n = {s2, shift[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    cnt_n   = FULL_LD;
                    if (bit_cnt == 3'd7) state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_n = cnt - 13'd1;
                end else if (s2) begin
                    data_n  = shift;
                    valid_n = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    ferr_n  = 1'b1;
                    state_n = S_BREAK;
                end
            end
            // Wait for the line to go high so a held-low
            // break cannot look like a new start edge.
            S_BREAK: begin
                if (s2) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLK_DIV=434).
// Table of frames plus hand-written glitch, break and reset cases.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int C = 434;
    localparam int H = C / 2;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       frame_err_o;
    logic       rx_busy_o;

    uart_rx #(.CLK_DIV(C)) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .uart_rx_i   (rx),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .frame_err_o (frame_err_o),
        .rx_busy_o   (rx_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        int         per;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } ev_t;

    vec_t       vecs[5];
    ev_t        q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         last_v_cyc = 0;
    logic [7:0] last_good = 8'h00;
    bit         prev_pulse = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int per,
                              input bit stop);
        t_start = cyc;
        rx = 1'b0;
        repeat (per) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (per) @(negedge clk_i);
        end
        rx = stop;
        repeat (per) @(negedge clk_i);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        chk(nm, q.size(), 0);
    endtask

    // Scoreboard: every output pulse pops one expected event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk_i);
            if (rx_valid_o || frame_err_o) begin
                chk("pulse_excl", int'(rx_valid_o & frame_err_o), 0);
                chk("pulse_width", int'(prev_pulse), 0);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: valid=%0b err=%0b want none",
                             rx_valid_o, frame_err_o);
                end else begin
                    e = q.pop_front();
                    chk("kind_err", int'(frame_err_o), int'(e.err));
                    if (!e.err) begin
                        chk("data", int'(rx_data_o), int'(e.data));
                        last_good  = e.data;
                        last_v_cyc = cyc;
                    end else begin
                        chk("err_hold", int'(rx_data_o), int'(last_good));
                    end
                end
            end
            prev_pulse = rx_valid_o | frame_err_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        int t0;
        vecs[0] = '{8'hA5, C,   200, 8'hA5};
        vecs[1] = '{8'h00, C,   0,   8'h00};
        vecs[2] = '{8'hFF, C,   300, 8'hFF};
        vecs[3] = '{8'h55, 425, 300, 8'h55};
        vecs[4] = '{8'h55, 443, 300, 8'h55};

        repeat (5) @(negedge clk_i);
        chk("rst_data", int'(rx_data_o), 0);
        chk("rst_valid", int'(rx_valid_o), 0);
        chk("rst_err", int'(frame_err_o), 0);
        chk("rst_busy", int'(rx_busy_o), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("idle_busy", int'(rx_busy_o), 0);

        for (int i = 0; i < 5; i++) begin
            q.push_back('{1'b0, vecs[i].exp});
            send_frame(vecs[i].data, vecs[i].per, 1'b1);
            if (i == 0) begin
                t0 = t_start;
                chk("latency", last_v_cyc - t0, H + 9 * C + 3);
            end
            repeat (vecs[i].gap) @(negedge clk_i);
        end
        drain("table_drain");

        // short low glitch aborts in START
        rx = 1'b0;
        repeat (100) @(negedge clk_i);
        rx = 1'b1;
        repeat (110) @(negedge clk_i);
        chk("glitch_busy_hi", int'(rx_busy_o), 1);
        repeat (20) @(negedge clk_i);
        chk("glitch_busy_lo", int'(rx_busy_o), 0);

        // bad stop bit, held-low break, recovery
        q.push_back('{1'b1, 8'h00});
        send_frame(8'h3C, C, 1'b0);
        repeat (2000) @(negedge clk_i);
        chk("break_busy", int'(rx_busy_o), 1);
        chk("break_data", int'(rx_data_o), 8'h55);
        chk("break_err_seen", q.size(), 0);
        rx = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("break_exit", int'(rx_busy_o), 0);
        q.push_back('{1'b0, 8'h81});
        send_frame(8'h81, C, 1'b1);
        repeat (100) @(negedge clk_i);
        drain("after_break");

        // reset during data bit 4 of 0xF0
        b = 8'hF0;
        rx = 1'b0;
        repeat (C) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk_i);
        end
        rx = b[4];
        repeat (100) @(negedge clk_i);
        rst_n = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        last_good = 8'h00;
        chk("mid_rst_data", int'(rx_data_o), 0);
        chk("mid_rst_valid", int'(rx_valid_o), 0);
        chk("mid_rst_err", int'(frame_err_o), 0);
        chk("mid_rst_busy", int'(rx_busy_o), 0);
        repeat (C - 100) @(negedge clk_i);
        for (int i = 5; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk_i);
        end
        rx = 1'b1;
        repeat (C + 500) @(negedge clk_i);
        chk("mid_rst_idle", int'(rx_busy_o), 0);
        q.push_back('{1'b0, 8'h12});
        send_frame(8'h12, C, 1'b1);
        repeat (100) @(negedge clk_i);
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
